khazad_sequencer: RTL and testbench
===================================

KHAZAD_SEQUENCER -- requirements
Module: khazad_sequencer

Interface
REQ-001 SHALL expose the following ports:
- CLK  in  1  single clock; all state on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle start pulse from controller.
- only_data  in  1  1 = reuse stored round keys; 0 = expand new key.
- enc_dec_SEL  in  1  1 = encrypt, 0 = decrypt.
- key_load  out  1  datapath loads the 128-bit key into K(-2)/K(-1) registers.
- ks_we  out  1  key-schedule step active; write K(ks_step) into the round-key RAM.
- ks_step  out  4  key-schedule step index, 0..8.
- data_load  out  1  datapath loads the plaintext/ciphertext and XORs it with the key at rk_addr.
- round_en  out  1  state register updates with a round result.
- round_idx  out  4  current round, 1..8; 0 outside rounds.
- last_round  out  1  current round omits theta (round 8).
- rk_addr  out  4  round-key RAM read address, 0..8.
- rk_theta  out  1  datapath applies theta to the read key (decryption key transform).
- finish  out  1  one-cycle done pulse to controller.
- busy  out  1  high in every state except IDLE.
REQ-002 Fixed decision: one clock; reset is asynchronous and active-low.

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, LOADK, KEYEXP, INIT, ROUND, DONE.
REQ-004 All outputs SHALL be decoded from registered state/counters only; no combinational path from any input to any output.
REQ-005 In IDLE, start=1 SHALL latch enc_dec_SEL into mode_r and SHALL go to LOADK if only_data=0 or key_valid=0, else to INIT.
REQ-006 start SHALL be ignored in every state other than IDLE; only_data and enc_dec_SEL SHALL be sampled only with an accepted start.
REQ-007 LOADK SHALL last 1 cycle with key_load=1, then go to KEYEXP with ks_step=0.
REQ-008 KEYEXP SHALL last 9 cycles with ks_we=1 and ks_step=0..8; after step 8 it SHALL set key_valid=1 and go to INIT.
REQ-009 INIT SHALL last 1 cycle with data_load=1 and rk_addr=0 (encrypt) or 8 (decrypt), rk_theta=0, then go to ROUND with round_idx=1.
REQ-010 ROUND SHALL last 8 cycles with round_en=1 and round_idx=1..8.
- rk_addr = round_idx (encrypt) or 8-round_idx (decrypt).
- rk_theta = 1 only when decrypting and round_idx is in 1..7.
- last_round = 1 exactly when round_idx=8.
REQ-011 After round 8, the FSM SHALL go to DONE: finish=1 for exactly 1 cycle, then return to IDLE.
REQ-012 Latency from the start cycle T SHALL be:
- with key expansion: LOADK at T+1, KEYEXP at T+2..T+10, INIT at T+11, rounds at T+12..T+19, finish at T+20.
- with reused key: INIT at T+1, rounds at T+2..T+9, finish at T+10.
REQ-013 The round-key RAM SHALL always hold encryption keys; decryption SHALL differ only in rk_addr/rk_theta, so a mode change with only_data=1 SHALL NOT trigger key expansion.
REQ-014 Counters (ks_step, round_idx) SHALL saturate/clear on state exit and SHALL never wrap past 8.
REQ-015 key_valid SHALL stay 1 until reset; an accepted start with only_data=0 SHALL always re-expand the key.

Reset
REQ-016 RST_N=0 SHALL immediately, without waiting for a clock edge:
- force state to IDLE;
- clear key_valid, mode_r, ks_step, round_idx;
- drive all outputs to 0, including finish and busy.
REQ-017 Reset asserted mid-operation SHALL abort without a finish pulse; the first start after reset SHALL perform key expansion regardless of only_data.
REQ-018 Release of RST_N SHALL take effect at the next CLK edge; start in that same cycle SHALL be accepted normally.

Verification
REQ-019 Reset, then start with only_data=1, enc_dec_SEL=1 -> LOADK/KEYEXP taken (key_valid=0); ks_step 0..8 at T+2..T+10; finish at T+20 only.
REQ-020 Second start with only_data=1, enc_dec_SEL=1 -> no key_load/ks_we; data_load at T+1; rk_addr 1..8 at T+2..T+9; last_round at T+9; finish at T+10.
REQ-021 Start with only_data=1, enc_dec_SEL=0 -> INIT rk_addr=8; rounds rk_addr 7,6,...,0; rk_theta=1 for rounds 1..7, 0 at round 8; finish at T+10.
REQ-022 Start pulses at T+3 and in the DONE cycle while busy -> ignored; exactly one finish; busy drops the cycle after finish.
REQ-023 RST_N low at T+6 of a full operation -> all outputs 0 asynchronously, no finish; next start with only_data=1 -> key_load at T'+1.
REQ-024 enc_dec_SEL toggled during ROUND -> rk_addr/rk_theta sequence unchanged (mode_r latched).

Source files
------------

// File: rtl/khazad_sequencer.sv
// Control sequencer for an iterated block cipher datapath: key load, 9-step key
// expansion into the round-key RAM, data load, 8 rounds, and a done pulse.
module khazad_sequencer (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start,
  input  logic       only_data,
  input  logic       enc_dec_SEL,
  output logic       key_load,
  output logic       ks_we,
  output logic [3:0] ks_step,
  output logic       data_load,
  output logic       round_en,
  output logic [3:0] round_idx,
  output logic       last_round,
  output logic [3:0] rk_addr,
  output logic       rk_theta,
  output logic       finish,
  output logic       busy
);

  // state  | meaning
  // IDLE   | waiting for start
  // LOADK  | key written into K(-2)/K(-1)
  // KEYEXP | round keys 0..8 computed and written to RAM
  // INIT   | plaintext/ciphertext loaded and whitened with key 0 or 8
  // ROUND  | rounds 1..8
  // DONE   | one-cycle finish pulse
  typedef enum logic [2:0] {IDLE, LOADK, KEYEXP, INIT, ROUND, DONE} state_t;

  state_t     state, state_nxt;
  logic       key_valid, key_valid_nxt;
  logic       mode_r, mode_nxt;
  logic [3:0] ks_cnt, ks_cnt_nxt;
  logic [3:0] rnd_cnt, rnd_cnt_nxt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      key_valid <= 1'b0;
      mode_r    <= 1'b0;
      ks_cnt    <= 4'd0;
      rnd_cnt   <= 4'd0;
    end else begin
      state     <= state_nxt;
      key_valid <= key_valid_nxt;
      mode_r    <= mode_nxt;
      ks_cnt    <= ks_cnt_nxt;
      rnd_cnt   <= rnd_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    key_valid_nxt = key_valid;
    mode_nxt      = mode_r;
    ks_cnt_nxt    = ks_cnt;
    rnd_cnt_nxt   = rnd_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          mode_nxt  = enc_dec_SEL;
          state_nxt = (!only_data || !key_valid) ? LOADK : INIT;
          if (only_data && key_valid) rnd_cnt_nxt = 4'd0;
        end
      end
      LOADK: begin
        state_nxt  = KEYEXP;
        ks_cnt_nxt = 4'd0;
      end
      KEYEXP: begin
        if (ks_cnt >= 4'd8) begin
          key_valid_nxt = 1'b1;
          ks_cnt_nxt    = 4'd0;
          state_nxt     = INIT;
        end else begin
          ks_cnt_nxt = ks_cnt + 4'd1;
        end
      end
      INIT: begin
        state_nxt   = ROUND;
        rnd_cnt_nxt = 4'd1;
      end
      ROUND: begin
        if (rnd_cnt >= 4'd8) begin
          rnd_cnt_nxt = 4'd0;
          state_nxt   = DONE;
        end else begin
          rnd_cnt_nxt = rnd_cnt + 4'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs depend only on registered state, counters and the latched mode.
  always_comb begin
    key_load   = (state == LOADK);
    ks_we      = (state == KEYEXP);
    ks_step    = (state == KEYEXP) ? ks_cnt : 4'd0;
    data_load  = (state == INIT);
    round_en   = (state == ROUND);
    round_idx  = (state == ROUND) ? rnd_cnt : 4'd0;
    last_round = (state == ROUND) && (rnd_cnt == 4'd8);
    finish     = (state == DONE);
    busy       = (state != IDLE);
    rk_addr    = 4'd0;
    rk_theta   = 1'b0;
    if (state == INIT) begin
      rk_addr = mode_r ? 4'd0 : 4'd8;
    end else if (state == ROUND) begin
      rk_addr  = mode_r ? rnd_cnt : (4'd8 - rnd_cnt);
      rk_theta = !mode_r && (rnd_cnt != 4'd8);
    end
  end

endmodule

// File: tb/tb_khazad_sequencer.sv
// Self-checking bench for khazad_sequencer: transaction table, directed corner
// sequences and random traffic, all checked cycle by cycle against a latency model.
module tb_khazad_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       start = 1'b0;
  logic       only_data = 1'b0;
  logic       enc_dec_SEL = 1'b0;
  logic       key_load, ks_we, data_load, round_en, last_round, rk_theta, finish, busy;
  logic [3:0] ks_step, round_idx, rk_addr;

  khazad_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .only_data(only_data),
    .enc_dec_SEL(enc_dec_SEL), .key_load(key_load), .ks_we(ks_we),
    .ks_step(ks_step), .data_load(data_load), .round_en(round_en),
    .round_idx(round_idx), .last_round(last_round), .rk_addr(rk_addr),
    .rk_theta(rk_theta), .finish(finish), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Transaction model: start cycle, whether it expands the key, latched mode.
  bit m_act = 0;
  bit m_ex = 0;
  bit m_md = 0;
  bit m_kv = 0;
  int m_T = 0;

  logic [19:0] act_v;
  assign act_v = {key_load, ks_we, ks_step, data_load, round_en, round_idx,
                  last_round, rk_addr, rk_theta, finish, busy};

  function automatic logic [19:0] model_out(int k, bit ex, bit md);
    logic kl, we, dl, ren, last, th, fin;
    logic [3:0] step, ridx, addr;
    int j, r;
    kl = 0; we = 0; dl = 0; ren = 0; last = 0; th = 0; fin = 0;
    step = 0; ridx = 0; addr = 0;
    j = k;
    if (ex) begin
      if (k == 1) kl = 1;
      else if (k <= 10) begin
        we = 1;
        step = 4'(k - 2);
      end
      j = k - 10;
    end
    if (j == 1) begin
      dl = 1;
      addr = md ? 4'd0 : 4'd8;
    end else if (j >= 2 && j <= 9) begin
      r = j - 1;
      ren = 1;
      ridx = 4'(r);
      last = (r == 8);
      addr = md ? 4'(r) : 4'(8 - r);
      th = !md && (r < 8);
    end else if (j == 10) begin
      fin = 1;
    end
    return {kl, we, step, dl, ren, ridx, last, addr, th, fin, 1'b1};
  endfunction

  function automatic int end_off(bit ex);
    return ex ? 20 : 10;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, req);
    end
  endtask

  task automatic check_outputs(input string nm);
    logic [19:0] exp_v;
    int k;
    k = cyc - m_T;
    exp_v = (m_act && RST_N && k >= 1 && k <= end_off(m_ex)) ? model_out(k, m_ex, m_md) : 20'd0;
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s cyc=%0d outputs actual=%h required=%h", nm, cyc, act_v, exp_v);
    end
  endtask

  task automatic cycle(input bit s, input bit od, input bit sel);
    start = s; only_data = od; enc_dec_SEL = sel;
    @(posedge CLK);
    if (RST_N && s && (!m_act || (cyc - m_T) > end_off(m_ex))) begin
      m_act = 1;
      m_T = cyc;
      m_ex = !od || !m_kv;
      m_md = sel;
      if (m_ex) m_kv = 1;
    end
    cyc++;
    #1;
    check_outputs("cycle");
  endtask

  task automatic do_reset();
    #2;
    RST_N = 0;
    m_act = 0;
    m_kv = 0;
    #1;
    check_outputs("async_reset");
    @(posedge CLK);
    cyc++;
    #1;
    check_outputs("reset_hold");
    RST_N = 1;
  endtask

  typedef struct {
    bit od;
    bit sel;
    bit exp_kl;
    int exp_lat;
    int exp_init_addr;
  } vec_t;

  vec_t tv[6];
  int T, lat, init_addr, nfin;
  bit saw_kl;

  initial begin
    tv[0] = '{od: 1, sel: 1, exp_kl: 1, exp_lat: 20, exp_init_addr: 0};
    tv[1] = '{od: 1, sel: 1, exp_kl: 0, exp_lat: 10, exp_init_addr: 0};
    tv[2] = '{od: 1, sel: 0, exp_kl: 0, exp_lat: 10, exp_init_addr: 8};
    tv[3] = '{od: 0, sel: 0, exp_kl: 1, exp_lat: 20, exp_init_addr: 8};
    tv[4] = '{od: 1, sel: 1, exp_kl: 0, exp_lat: 10, exp_init_addr: 0};
    tv[5] = '{od: 0, sel: 1, exp_kl: 1, exp_lat: 20, exp_init_addr: 0};

    #1;
    check_outputs("reset_state");
    @(posedge CLK);
    cyc++;
    #1;
    check_outputs("reset_state_edge");
    RST_N = 1;

    for (int v = 0; v < 6; v++) begin
      T = cyc;
      cycle(1, tv[v].od, tv[v].sel);
      saw_kl = 0; init_addr = -1; lat = -1;
      for (int n = 0; n < 40; n++) begin
        if (key_load) saw_kl = 1;
        if (data_load) init_addr = int'(rk_addr);
        if (finish) begin
          lat = cyc - T;
          break;
        end
        cycle(0, 0, 0);
      end
      chk($sformatf("vec%0d_key_load", v), int'(saw_kl), int'(tv[v].exp_kl));
      chk($sformatf("vec%0d_latency", v), lat, tv[v].exp_lat);
      chk($sformatf("vec%0d_init_addr", v), init_addr, tv[v].exp_init_addr);
      cycle(0, 0, 0);
      chk($sformatf("vec%0d_busy_after", v), int'(busy), 0);
    end

    // Start pulses while busy, including in the DONE cycle, are ignored.
    T = cyc;
    cycle(1, 1, 1);
    nfin = 0;
    while (cyc < T + 12) begin
      cycle((cyc == T + 3) || (cyc == T + 10), 1, 0);
      if (finish) nfin++;
    end
    chk("busy_start_single_finish", nfin, 1);
    chk("busy_start_idle_after", int'(busy), 0);

    // Reset during key expansion aborts; next start re-expands regardless of only_data.
    T = cyc;
    cycle(1, 0, 1);
    while (cyc < T + 6) cycle(0, 0, 0);
    do_reset();
    cycle(1, 1, 1);
    chk("reset_reexpand_key_load", int'(key_load), 1);
    nfin = 0;
    for (int n = 0; n < 22; n++) begin
      cycle(0, 1, 1);
      if (finish) nfin++;
    end
    chk("reset_reexpand_finish", nfin, 1);

    // Mode input toggled during rounds must not disturb the latched mode.
    T = cyc;
    cycle(1, 1, 0);
    for (int n = 0; n < 12; n++) cycle(0, 1, bit'((cyc % 2) == 1));

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      else cycle(bit'($urandom_range(0, 5) == 0), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
